// File: rtl/gfx_dac_pkg.sv
// Shared types and helpers for the gfx point-stream XY vector DAC driver.
package gfx_dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DWELL = 2'd2
  } gfx_dac_state_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_MOVE  = MOVE;
  localparam logic [1:0] ST_DWELL = DWELL;

  // Beam enables are the MSB of each RGB channel, red channel in the top bits.
  function automatic logic [2:0] rgb_msbs(input logic [63:0] pixel, input int pixel_width);
    int cw;
    cw = pixel_width / 3;
    return {pixel[pixel_width-1], pixel[2*cw-1], pixel[cw-1]};
  endfunction

endpackage

// File: rtl/gfx_dac_xy.sv
// Drives an XY vector DAC from a valid/ready point stream: blanked move, settle, lit dwell.
// Optional macro GFX_DAC_XY_SAME_POS_SKIP_EN skips the settle move when the position is unchanged.
//
// state | meaning
// IDLE  | ready for a point, beam blanked, DAC codes held
// MOVE  | DAC codes updated, beam blanked while the deflection settles
// DWELL | beam lit with the point's colour
module gfx_dac_xy
  import gfx_dac_pkg::*;
#(
  parameter int DAC_DATA_WIDTH = 10,
  parameter int H_WIDTH        = 12,
  parameter int V_WIDTH        = 12,
  parameter int PIXEL_WIDTH    = 12,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DWELL_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_gfx_valid,
  input  logic [H_WIDTH-1:0]        s_gfx_x,
  input  logic [V_WIDTH-1:0]        s_gfx_y,
  input  logic [PIXEL_WIDTH-1:0]    s_gfx_pixel,
  output logic                      s_gfx_ready,
  output logic [DAC_DATA_WIDTH-1:0] dac_x,
  output logic [DAC_DATA_WIDTH-1:0] dac_y,
  output logic                      dac_red,
  output logic                      dac_grn,
  output logic                      dac_blu
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                rgb_q;
  logic [DAC_DATA_WIDTH-1:0] x_code;
  logic [DAC_DATA_WIDTH-1:0] y_code;
  logic [2:0]                rgb_in;
  logic                      skip_move;
  logic                      unused_inputs;

  assign x_code = s_gfx_x[H_WIDTH-1 -: DAC_DATA_WIDTH];
  assign y_code = s_gfx_y[V_WIDTH-1 -: DAC_DATA_WIDTH];
  assign rgb_in = rgb_msbs(64'(s_gfx_pixel), PIXEL_WIDTH);
  assign unused_inputs = ^{s_gfx_x, s_gfx_y};

  always_comb begin
    skip_move = (SETTLE_CYCLES == 0);
`ifdef GFX_DAC_XY_SAME_POS_SKIP_EN
    if ((x_code == dac_x) && (y_code == dac_y)) skip_move = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rgb_q       <= '0;
      s_gfx_ready <= 1'b0;
      dac_x       <= '0;
      dac_y       <= '0;
      dac_red     <= 1'b0;
      dac_grn     <= 1'b0;
      dac_blu     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          {dac_red, dac_grn, dac_blu} <= 3'b000;
          if (s_gfx_valid && s_gfx_ready) begin
            s_gfx_ready <= 1'b0;
            dac_x       <= x_code;
            dac_y       <= y_code;
            rgb_q       <= rgb_in;
            if (skip_move) begin
              state                       <= ST_DWELL;
              cnt                         <= DWELL_LOAD;
              {dac_red, dac_grn, dac_blu} <= rgb_in;
            end else begin
              state <= ST_MOVE;
              cnt   <= SETTLE_LOAD;
            end
          end else begin
            s_gfx_ready <= 1'b1;
          end
        end
        ST_MOVE: begin
          if (cnt == '0) begin
            state                       <= ST_DWELL;
            cnt                         <= DWELL_LOAD;
            {dac_red, dac_grn, dac_blu} <= rgb_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DWELL: begin
          if (cnt == '0) begin
            state                       <= ST_IDLE;
            s_gfx_ready                 <= 1'b1;
            {dac_red, dac_grn, dac_blu} <= 3'b000;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          s_gfx_ready <= 1'b0;
          {dac_red, dac_grn, dac_blu} <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_dac_xy.sv
// Scoreboard bench for gfx_dac_xy: default timing and a zero-settle / single-dwell build side by side.
module tb_gfx_dac_xy;

  localparam int NPTS = 16;

  typedef struct {
    int         acc_edge;
    logic [9:0] cx;
    logic [9:0] cy;
    logic [2:0] rgb;
    int         seff;
  } item_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic logic [9:0] code_of(input logic [11:0] v);
    return 10'(v >> 2);
  endfunction

  function automatic logic [2:0] rgb_of(input logic [11:0] p);
    logic r, g, b;
    r = ((p >> 8) & 12'd15) >= 12'd8;
    g = ((p >> 4) & 12'd15) >= 12'd8;
    b = (p & 12'd15) >= 12'd8;
    return {r, g, b};
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int S = (g == 0) ? 4 : 0;
    localparam int D = (g == 0) ? 2 : 1;

    logic        rst;
    logic        valid;
    logic [11:0] x, y, pix;
    logic        ready;
    logic [9:0]  dx, dy;
    logic        red, grn, blu;
    int          edge_n = 0;
    logic        rst_q;
    logic        done = 1'b0;
    item_t       q[$];
    item_t       cur;
    logic        active = 1'b0;
    logic [9:0]  lx = '0, ly = '0;

    gfx_dac_xy #(
      .DAC_DATA_WIDTH(10), .H_WIDTH(12), .V_WIDTH(12), .PIXEL_WIDTH(12),
      .SETTLE_CYCLES(S), .DWELL_CYCLES(D)
    ) u_dut (
      .clk(clk), .rst(rst),
      .s_gfx_valid(valid), .s_gfx_x(x), .s_gfx_y(y), .s_gfx_pixel(pix),
      .s_gfx_ready(ready), .dac_x(dx), .dac_y(dy),
      .dac_red(red), .dac_grn(grn), .dac_blu(blu)
    );

    always @(posedge clk) begin
      edge_n <= edge_n + 1;
      rst_q  <= rst;
    end

    // Stimulus: acceptance timing comes from the point-rate rules, not from the DUT.
    initial begin
      int free, acc, seff, gap;
      logic same;
      logic [9:0] lcx, lcy;
      logic [11:0] px, py, pp;
      item_t it;
      rst = 1'b1; valid = 1'b0; x = '0; y = '0; pix = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; free = edge_n + 2; lcx = '0; lcy = '0;
      for (int i = 0; i < NPTS; i++) begin
        px = 12'($urandom); py = 12'($urandom); pp = 12'($urandom);
        gap = 0;
        case (i)
          0: begin px = 12'hABC; py = 12'h123; pp = 12'hF0F; end
          1: begin px = 12'h000; py = 12'hFFF; pp = 12'h000; gap = 1; end
          2: begin px = 12'h001; py = 12'hFFE; pp = 12'hFFF; end
          3, 4, 5: gap = 0;
          default: begin
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
              px = {lcx, 2'($urandom)};
              py = {lcy, 2'($urandom)};
            end
          end
        endcase
        repeat (gap) begin
          valid = 1'b0;
          @(posedge clk);
          #1;
        end
        valid = 1'b1; x = px; y = py; pix = pp;
        acc  = max_i(edge_n + 1, free);
        same = (code_of(px) == lcx) && (code_of(py) == lcy);
        seff = S;
`ifdef GFX_DAC_XY_SAME_POS_SKIP_EN
        if (same) seff = 0;
`endif
        it = '{acc_edge: acc, cx: code_of(px), cy: code_of(py), rgb: rgb_of(pp), seff: seff};
        q.push_back(it);
        free = acc + seff + D + 1;
        lcx = code_of(px); lcy = code_of(py);
        while (edge_n < acc) begin
          @(posedge clk);
          #1;
        end
        valid = 1'b0;
        if (i == 5) begin
          while (edge_n < acc + seff) begin
            @(posedge clk);
            #1;
          end
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst = 1'b0; free = edge_n + 2; lcx = '0; lcy = '0;
        end
      end
      while (edge_n < free + 2) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL cfg%0d pending_points: got %0d left, expected 0", g, q.size());
      end
      done = 1'b1;
    end

    // Monitor: expected outputs from the current scoreboard point; pops on each DUT handshake.
    always @(negedge clk) begin
      if (edge_n > 0) begin
        logic [23:0] exp_o, got_o;
        int m;
        if (rst_q) begin
          exp_o  = '0;
          active = 1'b0;
          lx = '0; ly = '0;
        end else begin
          m = edge_n - cur.acc_edge;
          if (active && m < cur.seff + D) begin
            exp_o = {1'b0, cur.cx, cur.cy, (m >= cur.seff) ? cur.rgb : 3'b000};
          end else begin
            active = 1'b0;
            exp_o  = {1'b1, lx, ly, 3'b000};
          end
        end
        got_o = {ready, dx, dy, red, grn, blu};
        checks++;
        if (got_o !== exp_o) begin
          failures++;
          $display("FAIL cfg%0d outputs at edge %0d: got rdy/x/y/rgb %h, expected %h", g, edge_n, got_o, exp_o);
        end
        if (valid && ready && !rst) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL cfg%0d accept at edge %0d: got accept, expected none", g, edge_n + 1);
          end else begin
            cur = q.pop_front();
            if (cur.acc_edge != edge_n + 1) begin
              failures++;
              $display("FAIL cfg%0d accept_time: got edge %0d, expected edge %0d", g, edge_n + 1, cur.acc_edge);
            end
            active = 1'b1;
            lx = cur.cx; ly = cur.cy;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    wait (g_cfg[0].done && g_cfg[1].done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gfx_dac_xy.md
Name: gfx_dac_xy

Overview:
- Consumer end of the gfx point stream: accepts (x, y, pixel) points over valid/ready and drives an XY vector DAC plus three beam-colour enables.
- Per point, the block moves the beam blanked, waits a settle time, then un-blanks with the point's colour for a dwell time.
- Sits at the output of the vector display path, downstream of any gfx point producer or FIFO, in the DAC clock domain.

Parameters:
- DAC_DATA_WIDTH, 10, DAC code width per axis
- H_WIDTH, 12, incoming x width; must be >= DAC_DATA_WIDTH
- V_WIDTH, 12, incoming y width; must be >= DAC_DATA_WIDTH
- PIXEL_WIDTH, 12, incoming pixel width; RGB, CW = PIXEL_WIDTH/3 bits per channel, red in the MSBs
- SETTLE_CYCLES, 4, blanked cycles after a DAC move; 0 is legal
- DWELL_CYCLES, 2, lit cycles per point; must be >= 1

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- s_gfx_valid  in  1  point valid
- s_gfx_x  in  H_WIDTH  point x
- s_gfx_y  in  V_WIDTH  point y
- s_gfx_pixel  in  PIXEL_WIDTH  point colour
- s_gfx_ready  out  1  block can accept a point
- dac_x  out  DAC_DATA_WIDTH  x DAC code
- dac_y  out  DAC_DATA_WIDTH  y DAC code
- dac_red  out  1  red beam enable
- dac_grn  out  1  green beam enable
- dac_blu  out  1  blue beam enable

Behaviour:
- Interface decision: one clock, clk; reset is rst, synchronous and active-high.
- All outputs are registered.
- Reset values: s_gfx_ready=0, dac_x=0, dac_y=0, dac_red/grn/blu=0, FSM=IDLE, counter=0.
- After reset: s_gfx_ready=1 on the first clock after rst deasserts.
- FSM IDLE:
  - s_gfx_ready=1, beam blanked, DAC codes hold their last value.
  - On s_gfx_valid && s_gfx_ready, the point is accepted (cycle T) and latched.
  - Transition: MOVE if SETTLE_CYCLES>0, else DWELL.
  - s_gfx_ready=0 from T+1.
- FSM MOVE:
  - At T+1: dac_x = s_gfx_x[H_WIDTH-1 -: DAC_DATA_WIDTH]; dac_y = y MSBs in the same way (truncation, no rounding); colours=0.
  - Stay SETTLE_CYCLES cycles (T+1 .. T+SETTLE_CYCLES), then go to DWELL.
- FSM DWELL:
  - Colours on for DWELL_CYCLES cycles.
  - dac_red = pixel[PW-1], dac_grn = pixel[2*CW-1], dac_blu = pixel[CW-1] (channel MSB threshold).
  - If SETTLE_CYCLES=0, the DAC codes and colours update together at T+1.
  - After the last dwell cycle: colours=0, s_gfx_ready=1, back to IDLE.
- Throughput: one point per 1+SETTLE_CYCLES+DWELL_CYCLES cycles. Defaults: 7 cycles/point.
- A pixel of 0 still runs settle and dwell, with the beam dark (blank move).
- s_gfx_valid held low: remain in IDLE, blanked, DAC codes hold (no parking).
- Inputs are ignored while s_gfx_ready=0. Upstream must hold its data stable per valid/ready rules.
- Reset mid-operation: the next clock forces all reset values, including dac_x/y=0. The in-flight point is dropped, never resumed.
- Counter width: $clog2(max(SETTLE_CYCLES, DWELL_CYCLES)+1). It loads N-1 on state entry and exits the state at 0.

Optional Feature:
- Macro: GFX_DAC_XY_SAME_POS_SKIP_EN.
- Defined: if the accepted point's truncated DAC codes equal the current dac_x/dac_y, MOVE is skipped and the FSM goes straight to DWELL. Points on an unchanged position then cost 1+DWELL_CYCLES cycles.
- Not defined: MOVE always runs, even for identical positions.

Decomposition:
- Shared package gfx_dac_pkg holds:
  - FSM state enum {IDLE, MOVE, DWELL}
  - function for RGB-channel MSB extraction, given PIXEL_WIDTH
- No sub-module. FSM, counter and output registers stay in one module.

Test Plan:
- Reset then single point x=12'hABC, y=12'h123, pixel=12'hF0F with defaults:
  - dac_x=10'h2AF and dac_y=10'h048 at T+1
  - colours 0 for T+1..T+4
  - red=1, grn=0, blu=1 at T+5..T+6
  - s_gfx_ready=1 at T+7
- Back-to-back valid for 3 points: exactly one accept every 7 cycles; no accept while ready=0; DAC codes change only at accept+1.
- SETTLE_CYCLES=0, DWELL_CYCLES=1:
  - DAC codes and colours update at T+1
  - ready=1 at T+2
  - sustained rate of 1 point per 2 cycles
- pixel=0 at x=0, y=12'hFFF: dac_y=10'h3FF and colours stay 0 for the whole sequence.
- Assert rst during DWELL:
  - next cycle, all outputs are at reset values and ready=0
  - ready=1 one cycle after rst drops
  - the next point runs the full sequence
- With GFX_DAC_XY_SAME_POS_SKIP_EN, two identical points: the second lights at accept+1, ready at accept+3. Without the macro, the second follows the standard 7-cycle timing.
